// File: rtl/vga_sync_gen_if.sv
// Timing-stage bus: raw counts in, decoded sync/video/strobe/status out.
// The slave modport is the sync generator; the master modport is whoever drives the counts.
interface vga_sync_gen_if;
    logic       pixtick;
    logic [9:0] cntHorizontal;
    logic [9:0] cntVertical;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       line_start;
    logic       frame_start;
    logic [1:0] vphase;
    logic [7:0] frame_count;
    logic       timing_err;

    modport slave (
        input  pixtick, cntHorizontal, cntVertical,
        output hsync, vsync, video_on, pixel_x, pixel_y,
        output line_start, frame_start, vphase, frame_count, timing_err
    );

    modport master (
        output pixtick, cntHorizontal, cntVertical,
        input  hsync, vsync, video_on, pixel_x, pixel_y,
        input  line_start, frame_start, vphase, frame_count, timing_err
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing stage: turns the horizontal/vertical counts into registered sync pulses,
// active-area coordinates, line/frame strobes, a frame counter and a vertical-phase FSM.
// All state advances only on Clk edges that carry a pixtick. A sticky error flag records
// any count that is out of range or any vertical count that does not follow its predecessor.
module vga_sync_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 29,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    vga_sync_gen_if.slave         io_sync
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 10-bit copies of the decode boundaries so every compare is width-matched.
    localparam logic [9:0] HActive  = 10'(H_ACTIVE);
    localparam logic [9:0] HsStart  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HsEnd    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] HTotal   = 10'(H_TOTAL);
    localparam logic [9:0] VActive  = 10'(V_ACTIVE);
    localparam logic [9:0] VsStart  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VsEnd    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] VTotal   = 10'(V_TOTAL);
    localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        VpActive = 2'd0,
        VpFront  = 2'd1,
        VpSync   = 2'd2,
        VpBack   = 2'd3
    } vphase_e;

    vphase_e     r_vphase;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_video_on;
    logic [9:0]  r_pixel_x;
    logic [9:0]  r_pixel_y;
    logic        r_line_start;
    logic        r_frame_start;
    logic [7:0]  r_frame_count;
    logic        r_timing_err;
    logic [9:0]  r_last_v;
    logic        r_last_v_vld;

    logic [9:0]  w_h;
    logic [9:0]  w_v;
    logic        w_out_of_range;
    logic        w_line_tick;
    logic        w_frame_tick;
    logic        w_video;
    logic        w_hs_active;
    logic [9:0]  w_v_expected;
    logic        w_v_seq_bad;
    vphase_e     w_vphase_nxt;

    assign w_h            = io_sync.cntHorizontal;
    assign w_v            = io_sync.cntVertical;
    assign w_out_of_range = (w_h >= HTotal) || (w_v >= VTotal);
    assign w_line_tick    = (w_h == 10'd0);
    assign w_frame_tick   = w_line_tick && (w_v == 10'd0);
    assign w_video        = !w_out_of_range && (w_h < HActive) && (w_v < VActive);
    assign w_hs_active    = (w_h >= HsStart) && (w_h < HsEnd);

    // The line after the last one wraps to 0; the first line after Reset has no predecessor.
    assign w_v_expected   = (r_last_v == VLast) ? 10'd0 : r_last_v + 10'd1;
    assign w_v_seq_bad    = w_line_tick && r_last_v_vld && (w_v != w_v_expected);

    // Vertical phase advances only at line starts and only on its exact boundary lines,
    // so an out-of-range v can never move it.
    always_comb begin
        w_vphase_nxt = r_vphase;
        if (w_line_tick) begin
            unique case (r_vphase)
                VpActive: if (w_v == VActive) w_vphase_nxt = VpFront;
                VpFront:  if (w_v == VsStart) w_vphase_nxt = VpSync;
                VpSync:   if (w_v == VsEnd)   w_vphase_nxt = VpBack;
                VpBack:   if (w_v == 10'd0)   w_vphase_nxt = VpActive;
                default:                      w_vphase_nxt = VpActive;
            endcase
        end
    end

    // Registered decode, FSM state, counters and error flag; everything holds between ticks
    // except the strobes, which last exactly one Clk.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_vphase      <= VpActive;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_video_on    <= 1'b0;
            r_pixel_x     <= 10'd0;
            r_pixel_y     <= 10'd0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= 8'd0;
            r_timing_err  <= 1'b0;
            r_last_v      <= 10'd0;
            r_last_v_vld  <= 1'b0;
        end else if (io_sync.pixtick) begin
            r_vphase      <= w_vphase_nxt;
            r_hsync       <= w_hs_active ? SYNC_POL : ~SYNC_POL;
            // vsync follows the next phase so both change in the same Clk.
            r_vsync       <= (w_vphase_nxt == VpSync) ? SYNC_POL : ~SYNC_POL;
            r_video_on    <= w_video;
            r_pixel_x     <= w_video ? w_h : 10'd0;
            r_pixel_y     <= w_video ? w_v : 10'd0;
            r_line_start  <= w_line_tick;
            r_frame_start <= w_frame_tick;
            if (w_frame_tick) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
            if (w_out_of_range || w_v_seq_bad) begin
                r_timing_err <= 1'b1;
            end
            if (w_line_tick) begin
                r_last_v     <= w_v;
                r_last_v_vld <= 1'b1;
            end
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign io_sync.hsync       = r_hsync;
    assign io_sync.vsync       = r_vsync;
    assign io_sync.video_on    = r_video_on;
    assign io_sync.pixel_x     = r_pixel_x;
    assign io_sync.pixel_y     = r_pixel_y;
    assign io_sync.line_start  = r_line_start;
    assign io_sync.frame_start = r_frame_start;
    assign io_sync.vphase      = r_vphase;
    assign io_sync.frame_count = r_frame_count;
    assign io_sync.timing_err  = r_timing_err;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a reference model pushes the expected output set into a queue each
// time inputs are driven, and that entry is compared one Clk later. A table of hand-derived
// vectors and short hand-written sequences cover the boundaries and multi-cycle cases.
module tb_vga_sync_gen;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    vga_sync_gen_if u_if ();

    vga_sync_gen u_dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .io_sync (u_if)
    );

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       von;
        logic [9:0] px;
        logic [9:0] py;
        logic       ls;
        logic       fs;
        logic [1:0] vph;
        logic [7:0] fc;
        logic       err;
    } out_t;

    typedef struct {
        int   h;
        int   v;
        out_t exp;
    } vec_t;

    out_t       sb_q[$];
    out_t       m;
    int         m_lastv;
    bit         m_seen;
    int         n_vec = 0;
    int         n_bad = 0;
    vec_t       tbl[10];

    function automatic out_t dut_out();
        out_t o;
        o.hs  = u_if.hsync;
        o.vs  = u_if.vsync;
        o.von = u_if.video_on;
        o.px  = u_if.pixel_x;
        o.py  = u_if.pixel_y;
        o.ls  = u_if.line_start;
        o.fs  = u_if.frame_start;
        o.vph = u_if.vphase;
        o.fc  = u_if.frame_count;
        o.err = u_if.timing_err;
        return o;
    endfunction

    // Reference behaviour for one Clk of inputs.
    task automatic model_tick(input bit rst, input bit pt, input int h, input int v);
        bit oor;
        int nxt;
        if (rst) begin
            m       = '0;
            m.hs    = 1'b1;
            m.vs    = 1'b1;
            m_lastv = 0;
            m_seen  = 1'b0;
        end else if (!pt) begin
            m.ls = 1'b0;
            m.fs = 1'b0;
        end else begin
            oor   = (h >= 800) || (v >= 521);
            m.von = !oor && (h < 640) && (v < 480);
            m.px  = m.von ? 10'(h) : 10'd0;
            m.py  = m.von ? 10'(v) : 10'd0;
            m.hs  = !((h >= 656) && (h <= 751));
            m.ls  = (h == 0);
            m.fs  = (h == 0) && (v == 0);
            if (m.fs) m.fc = m.fc + 8'd1;
            if (h == 0) begin
                if (m.vph == 2'd0 && v == 480)      m.vph = 2'd1;
                else if (m.vph == 2'd1 && v == 490) m.vph = 2'd2;
                else if (m.vph == 2'd2 && v == 492) m.vph = 2'd3;
                else if (m.vph == 2'd3 && v == 0)   m.vph = 2'd0;
                nxt = (m_lastv == 520) ? 0 : m_lastv + 1;
                if (m_seen && v != nxt) m.err = 1'b1;
                m_lastv = v;
                m_seen  = 1'b1;
            end
            if (oor) m.err = 1'b1;
            m.vs = (m.vph != 2'd2);
        end
    endtask

    // Compare the result of the previous Clk's inputs, then drive and predict the next one.
    task automatic step(input bit rst, input bit pt, input int h, input int v);
        out_t e;
        out_t a;
        @(negedge Clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = dut_out();
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL scoreboard t=%0t got hs=%b vs=%b von=%b px=%0d py=%0d ls=%b fs=%b vph=%0d fc=%0d err=%b expected hs=%b vs=%b von=%b px=%0d py=%0d ls=%b fs=%b vph=%0d fc=%0d err=%b",
                         $time, a.hs, a.vs, a.von, a.px, a.py, a.ls, a.fs, a.vph, a.fc, a.err,
                         e.hs, e.vs, e.von, e.px, e.py, e.ls, e.fs, e.vph, e.fc, e.err);
            end
        end
        Reset              = rst;
        u_if.pixtick       = pt;
        u_if.cntHorizontal = 10'(h);
        u_if.cntVertical   = 10'(v);
        model_tick(rst, pt, h, v);
        sb_q.push_back(m);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int h, input int v, input bit von, input bit hs,
                                input int px, input int py, input bit ls, input bit fs);
        vec_t t;
        t.h       = h;
        t.v       = v;
        t.exp     = '0;
        t.exp.hs  = hs;
        t.exp.vs  = 1'b1;
        t.exp.von = von;
        t.exp.px  = 10'(px);
        t.exp.py  = 10'(py);
        t.exp.ls  = ls;
        t.exp.fs  = fs;
        t.exp.fc  = 8'd1;
        return t;
    endfunction

    initial begin
        out_t a;
        int   exp_vph;

        //           h    v    von hs  px   py   ls fs
        tbl[0] = mk(0,   0,   1, 1, 0,   0,   1, 1);
        tbl[1] = mk(639, 0,   1, 1, 639, 0,   0, 0);
        tbl[2] = mk(640, 0,   0, 1, 0,   0,   0, 0);
        tbl[3] = mk(655, 0,   0, 1, 0,   0,   0, 0);
        tbl[4] = mk(656, 0,   0, 0, 0,   0,   0, 0);
        tbl[5] = mk(751, 0,   0, 0, 0,   0,   0, 0);
        tbl[6] = mk(752, 0,   0, 1, 0,   0,   0, 0);
        tbl[7] = mk(799, 0,   0, 1, 0,   0,   0, 0);
        tbl[8] = mk(5,   479, 1, 1, 5,   479, 0, 0);
        tbl[9] = mk(5,   480, 0, 1, 0,   0,   0, 0);

        // Reset state.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        a = dut_out();
        chk("reset_hsync", a.hs, 1);
        chk("reset_vsync", a.vs, 1);
        chk("reset_video_on", a.von, 0);
        chk("reset_vphase", a.vph, 0);
        chk("reset_frame_count", a.fc, 0);
        chk("reset_timing_err", a.err, 0);

        // Table vectors, each followed by an idle Clk so outputs settle before comparing.
        for (int i = 0; i < 10; i++) begin
            step(0, 1, tbl[i].h, tbl[i].v);
            step(0, 0, tbl[i].h, tbl[i].v);
            a = dut_out();
            n_vec++;
            if (a !== tbl[i].exp) begin
                n_bad++;
                $display("FAIL table[%0d] h=%0d v=%0d: got %h expected %h",
                         i, tbl[i].h, tbl[i].v, a, tbl[i].exp);
            end
        end

        // Full line sweep, pixtick every 4 Clk.
        step(1, 0, 0, 0);
        for (int h = 0; h < 800; h++) begin
            step(0, 1, h, 0);
            step(0, 0, h, 0);
            if (h == 700) chk("pixel_x_at_700", u_if.pixel_x, 0);
            if (h == 100) chk("pixel_x_at_100", u_if.pixel_x, 100);
            step(0, 0, h, 0);
            step(0, 0, h, 0);
        end

        // One frame of lines; check the phase and vsync at every boundary.
        step(1, 0, 0, 0);
        for (int v = 0; v < 521; v++) begin
            step(0, 1, 0, v);
            step(0, 1, 400, v);
            if (v == 479 || v == 480 || v == 489 || v == 490 || v == 491 ||
                v == 492 || v == 520) begin
                exp_vph = (v < 480) ? 0 : (v < 490) ? 1 : (v < 492) ? 2 : 3;
                chk($sformatf("vphase_v%0d", v), u_if.vphase, exp_vph);
                chk($sformatf("vsync_v%0d", v), u_if.vsync, (exp_vph == 2) ? 0 : 1);
            end
        end
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("frame_wrap_vphase", u_if.vphase, 0);
        chk("frame_wrap_frame_start", u_if.frame_start, 1);
        chk("frame_wrap_frame_count", u_if.frame_count, 2);
        chk("frame_clean_err", u_if.timing_err, 0);

        // frame_count wrap via 256 frame-start ticks.
        step(1, 0, 0, 0);
        for (int i = 0; i < 255; i++) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("frame_count_255", u_if.frame_count, 255);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("frame_count_wrap", u_if.frame_count, 0);

        // Vertical sequence error, Reset together with pixtick.
        step(1, 1, 0, 0);
        step(0, 1, 0, 100);
        step(0, 1, 0, 101);
        step(0, 0, 0, 101);
        chk("seq_ok_err", u_if.timing_err, 0);
        step(0, 1, 0, 103);
        step(0, 0, 0, 103);
        chk("seq_skip_err", u_if.timing_err, 1);
        step(0, 1, 0, 104);
        step(0, 1, 0, 105);
        step(0, 0, 0, 105);
        chk("seq_err_sticky", u_if.timing_err, 1);

        // Out-of-range horizontal count.
        step(1, 0, 0, 0);
        step(0, 1, 850, 0);
        step(0, 0, 850, 0);
        chk("h_oor_err", u_if.timing_err, 1);
        chk("h_oor_video_on", u_if.video_on, 0);
        step(0, 1, 10, 600);

        // pixtick held low mid-line: outputs frozen, strobes drop.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        chk("strobe_high", u_if.line_start, 1);
        step(0, 0, 0, 1);
        chk("strobe_drop", u_if.line_start, 0);
        step(0, 1, 300, 10);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, $urandom_range(0, 799), $urandom_range(0, 520));
        end
        chk("frozen_pixel_x", u_if.pixel_x, 300);
        chk("frozen_pixel_y", u_if.pixel_y, 10);

        // Reset while in the back porch, then resume from line 0.
        step(1, 0, 0, 0);
        for (int v = 0; v < 496; v++) step(0, 1, 0, v);
        step(0, 0, 0, 495);
        chk("back_vphase", u_if.vphase, 3);
        step(1, 1, 0, 495);
        step(0, 0, 0, 495);
        chk("rst_mid_vsync", u_if.vsync, 1);
        chk("rst_mid_vphase", u_if.vphase, 0);
        chk("rst_mid_frame_count", u_if.frame_count, 0);
        chk("rst_mid_err", u_if.timing_err, 0);
        for (int v = 0; v < 6; v++) step(0, 1, 0, v);
        step(0, 0, 0, 5);
        chk("resume_err", u_if.timing_err, 0);
        chk("resume_frame_count", u_if.frame_count, 1);
        step(0, 0, 0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
